// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise truncates.
module fp_addsub_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [2:0]               flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = EXP_W + MAN_W;
    localparam int XW   = MAN_W + 4;
    localparam int SW   = MAN_W + 5;
    localparam int EW   = EXP_W + 2;
    localparam int LZW  = $clog2(XW) + 1;
    localparam int EMAX = 2**EXP_W - 1;

    localparam logic signed [EW-1:0] ONE   = EW'(1);
    localparam logic signed [EW-1:0] ZERO  = '0;
    localparam logic signed [EW-1:0] EMAXS = EW'(EMAX);

    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage 1: classify, flush, swap and align
    logic             sa, sb, bs, ss;
    logic             a_max, b_max, a_nan, b_nan, a_inf, b_inf;
    logic             nan1, inf1, swap;
    logic [MW-1:0]    ma, mb, mbig, msml;
    logic [EXP_W-1:0] be, se, d;
    logic [LZW-1:0]   dc;
    logic [XW-1:0]    sig_b, sig_s, sml_x;
    logic [2*XW-1:0]  wide;

    always_comb begin
        sa    = a[W-1];
        sb    = b[W-1] ^ sub;
        a_max = &a[W-2:MAN_W];
        b_max = &b[W-2:MAN_W];
        a_nan = a_max & (|a[MAN_W-1:0]);
        b_nan = b_max & (|b[MAN_W-1:0]);
        a_inf = a_max & ~(|a[MAN_W-1:0]);
        b_inf = b_max & ~(|b[MAN_W-1:0]);
        nan1  = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
        inf1  = (a_inf | b_inf) & ~nan1;
        ma    = (|a[W-2:MAN_W]) ? a[W-2:0] : '0;
        mb    = (|b[W-2:MAN_W]) ? b[W-2:0] : '0;
        swap  = mb > ma;
        bs    = swap ? sb : sa;
        ss    = swap ? sa : sb;
        mbig  = swap ? mb : ma;
        msml  = swap ? ma : mb;
        be    = mbig[MW-1:MAN_W];
        se    = msml[MW-1:MAN_W];
        sig_b = {|be, mbig[MAN_W-1:0], 3'b000};
        sig_s = {|se, msml[MAN_W-1:0], 3'b000};
        d     = be - se;
        if (32'(d) > XW)
            dc = LZW'(XW);
        else
            dc = LZW'(d);
        // Low half of the wide shift catches every bit pushed out
        wide  = {sig_s, {XW{1'b0}}} >> dc;
        sml_x = {wide[2*XW-1:XW+1], wide[XW] | (|wide[XW-1:0])};
    end

    logic             v1, s1_sign, s1_sub, s1_nan, s1_inf;
    logic [EXP_W-1:0] s1_exp;
    logic [XW-1:0]    s1_big, s1_small;

    // Stage 2: significand add/subtract
    logic [SW-1:0] sum2;
    logic          sign2;

    always_comb begin
        if (s1_sub)
            sum2 = {1'b0, s1_big} - {1'b0, s1_small};
        else
            sum2 = {1'b0, s1_big} + {1'b0, s1_small};
        sign2 = s1_sign;
        if (s1_sub && !(|sum2) && !s1_inf)
            sign2 = 1'b0;
    end

    logic                    v2, s2_sign, s2_nan, s2_inf;
    logic signed [EW-1:0]    s2_exp;
    logic [SW-1:0]           s2_sum;

    // Stage 3: normalise, round, pack
    logic [LZW-1:0]       lz;
    logic [XW-2:0]        nfr;
    logic signed [EW-1:0] e_n, e_r;
    logic [MAN_W-1:0]     frac_o;
    logic [W-1:0]         res;
    logic [2:0]           fl;
`ifdef FP_ADDSUB_RNE_EN
    logic                 inc, rc;
`endif

    always_comb begin
        lz = '0;
        for (int i = 0; i < XW; i++)
            if (s2_sum[i])
                lz = LZW'(XW - 1 - i);
        if (s2_sum[SW-1]) begin
            nfr = {s2_sum[SW-2:2], s2_sum[1] | s2_sum[0]};
            e_n = s2_exp + ONE;
        end else begin
            nfr = (XW-1)'(s2_sum[XW-1:0] << lz);
            e_n = s2_exp - signed'(EW'(lz));
        end
`ifdef FP_ADDSUB_RNE_EN
        inc          = nfr[2] & (nfr[1] | nfr[0] | nfr[3]);
        {rc, frac_o} = {1'b0, nfr[XW-2:3]} + (MAN_W+1)'(inc);
        e_r          = rc ? e_n + ONE : e_n;
`else
        frac_o = MAN_W'(nfr >> 3);
        e_r    = e_n;
`endif
        res = '0;
        fl  = 3'b000;
        if (s2_nan) begin
            res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            fl  = 3'b100;
        end else if (s2_inf) begin
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (!(|s2_sum)) begin
            res = {s2_sign, {(W-1){1'b0}}};
        end else if (e_r >= EMAXS) begin
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            fl  = 3'b010;
        end else if (e_r <= ZERO) begin
            res = {s2_sign, {(W-1){1'b0}}};
            fl  = 3'b001;
        end else begin
            res = {s2_sign, e_r[EXP_W-1:0], frac_o};
        end
    end

    // One global enable: a stalled output freezes every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (!stall) begin
            v1        <= in_valid;
            s1_sign   <= inf1 ? (a_inf ? sa : sb) : bs;
            s1_sub    <= bs ^ ss;
            s1_nan    <= nan1;
            s1_inf    <= inf1;
            s1_exp    <= be;
            s1_big    <= sig_b;
            s1_small  <= sml_x;
            v2        <= v1;
            s2_sign   <= sign2;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_exp    <= signed'(EW'(s1_exp));
            s2_sum    <= sum2;
            out_valid <= v2;
            result    <= res;
            flags     <= fl;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed scoreboard bench for fp_addsub_pipe (default parameters).
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    typedef struct {
        logic [15:0] r;
        logic [2:0]  f;
        int          id;
    } exp_t;

    exp_t        sbq[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          next_id  = 0;
    logic        held_v   = 1'b0;
    logic [18:0] held;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] half(input int n);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 5'(15 + e), 10'(((n << 10) >> e) & 'h3FF)};
    endfunction

    // Output monitor: pops the scoreboard on every transfer
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid) begin
            if (held_v)
                chk("hold_stable", {13'b0, result, flags}, {13'b0, held});
            if (out_ready) begin
                chk("queue_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk($sformatf("result_%0d", e.id), result, e.r);
                    chk($sformatf("flags_%0d", e.id), flags, e.f);
                    n_out++;
                end
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held   = {result, flags};
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic [15:0] er,
                        input logic [2:0] ef);
        exp_t e;
        int   k = 0;
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        e.r = er; e.f = ef; e.id = next_id;
        next_id++;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 100) chk("accept_timeout", in_ready, 1);
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() > 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        int idx, base;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000);
        in_valid = 1'b0;
        chk("lat_1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_2", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_3", out_valid, 1);
        drain();

        send(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000);
        send(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b010);
        send(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100);
        send(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000);
`ifdef FP_ADDSUB_RNE_EN
        send(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b000);
        send(16'h3C01, 16'h1001, 1'b0, 16'h3C02, 3'b000);
`else
        send(16'h3C01, 16'h1000, 1'b0, 16'h3C01, 3'b000);
        send(16'h3C01, 16'h1001, 1'b0, 16'h3C01, 3'b000);
`endif
        send(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b000);
        send(16'h0001, 16'h3C00, 1'b0, 16'h3C00, 3'b000);
        send(16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b001);
        send(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000);
        send(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b100);
        send(16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000);
        in_valid = 1'b0;
        drain();

        // Eight back-to-back pairs, consumer stalls in cycles 4..6
        idx  = 0;
        base = n_out;
        for (int c = 0; c < 24; c++) begin
            out_ready = !(c >= 4 && c <= 6);
            in_valid  = idx < 8;
            if (idx < 8) begin
                a   = (idx % 2 == 0) ? half(idx + 1) : half(idx + 5);
                b   = half(2);
                sub = idx % 2;
            end
            @(negedge clk);
            if (c < 14)
                chk($sformatf("ready_c%0d", c), in_ready,
                    !(c >= 4 && c <= 6));
            if (in_valid && in_ready) begin
                e.r = half(idx + 3); e.f = 3'b000; e.id = next_id;
                next_id++;
                sbq.push_back(e);
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("stream_count", n_out - base, 8);

        // Reset with two operations in flight
        send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000);
        send(16'h4000, 16'h3C00, 1'b0, 16'h4200, 3'b000);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_flush_valid", out_valid, 0);
        sbq.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_flush_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("no_stale_%0d", i), out_valid, 0);
            @(posedge clk); #1;
        end

        send(16'h4000, 16'h3C00, 1'b0, 16'h4200, 3'b000);
        in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
